// File: rtl/rib_sram_resp.sv
// RIB-bus data-port responder backed by a word-wide synchronous SRAM with multi-cycle reads.
// Define RIB_SRAM_RDBUF_EN to add a one-entry read buffer that serves repeat reads without stalling.
module rib_sram_resp #(
    parameter int ADDR_W      = 12,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        hold_o
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t            state, state_next;
    logic [3:0]        cnt, cnt_next;
    logic [ADDR_W-1:0] idx, idx_next;
    logic [ADDR_W-1:0] word;
    logic [31:0]       mem [2**ADDR_W];
    logic              rd, wr, hit, load, hold;
    logic              unused_addr;

    assign word        = addr_i[ADDR_W+1:2];
    assign unused_addr = ^{addr_i[31:ADDR_W+2], addr_i[1:0]};
    assign rd          = req_i & ~we_i;
    assign wr          = req_i & we_i;

`ifdef RIB_SRAM_RDBUF_EN
    logic              buf_valid;
    logic [ADDR_W-1:0] buf_idx;
    logic [31:0]       buf_data;

    assign hit = rd && (state != BUSY) && buf_valid && (word == buf_idx);

    // The buffer always mirrors the most recently completed read and tracks writes to that word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_valid <= 1'b0;
            buf_idx   <= '0;
            buf_data  <= '0;
        end else if (load) begin
            buf_valid <= 1'b1;
            buf_idx   <= word;
            buf_data  <= mem[word];
        end else if (wr && buf_valid && (word == buf_idx)) begin
            buf_data  <= data_i;
        end
    end
`else
    assign hit = 1'b0;
`endif

    // A write always wins and aborts any read; a read not continuing the latched one starts over.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        hold       = 1'b0;
        load       = 1'b0;
        if (wr) begin
            state_next = IDLE;
        end else if (rd) begin
            if (state == BUSY && word == idx) begin
                hold     = 1'b1;
                cnt_next = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    state_next = DONE;
                    load       = 1'b1;
                end
            end else if (hit) begin
                state_next = DONE;
            end else begin
                hold     = 1'b1;
                idx_next = word;
                cnt_next = CNT_INIT;
                if (WAIT_CYCLES == 1) begin
                    state_next = DONE;
                    load       = 1'b1;
                end else begin
                    state_next = BUSY;
                end
            end
        end else begin
            state_next = IDLE;
        end
    end

    // Gating with reset drops the stall the moment reset asserts, even with a read still presented.
    assign hold_o = hold & rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            data_o <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            idx   <= idx_next;
            if (load) begin
                data_o <= mem[word];
            end
`ifdef RIB_SRAM_RDBUF_EN
            else if (hit) begin
                data_o <= buf_data;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[word] <= data_i;
        end
    end

endmodule
